writeback_unit: RTL

- W-stage consumer of the M→W pipeline register outputs.
- Selects the writeback result and commits it to a 32×32 architectural register file.
- Serves decode-stage register reads with same-cycle write bypass.
- Forwards M/W results back to E-stage operands.
- Keeps a 64-bit retired-instruction counter.
- Sits at the tail of the 5-stage pipeline and closes the loop back into D and E.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/reg_file.sv | 57 +++++
 rtl/writeback_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types, widths and the operand-forwarding selector
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_e;

    // M wins over W because it holds the younger producer of the same register.
    // x0 is never forwarded: it reads as zero regardless of what is in flight.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_IDX_W-1:0] rs,
        input logic                 wr_m,
        input logic [REG_IDX_W-1:0] rd_m,
        input logic                 wr_w,
        input logic [REG_IDX_W-1:0] rd_w
    );
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (rs != '0) begin
            if (wr_m && (rd_m == rs)) begin
                sel = FWD_M;
            end else if (wr_w && (rd_w == rs)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file, 2 read / 1 write, write-first bypass
//   clk, rst            : clock, synchronous active-high reset (clears every register)
//   we, waddr, wdata    : write port; writes to x0 are ignored
//   raddr1/2, rdata1/2  : combinational read ports; x0 reads 0, a same-cycle write is bypassed
//   dbg_a0              : stored contents of x10
module reg_file
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_IDX_W-1:0]  raddr1,
    input  logic [REG_IDX_W-1:0]  raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] dbg_a0
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    // Decode reads in the same cycle W commits, so the write is returned directly
    // instead of waiting for it to land in storage.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = (wr_live && (waddr == raddr1)) ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = (wr_live && (waddr == raddr2)) ? wdata : regs[raddr2];
        end
    end

    assign dbg_a0 = regs[10];

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - W stage: result select, register commit, D reads, E forwarding, retire count
//   clk, rst                          : clock, synchronous active-high reset
//   ValidW, RegWriteW, ResultSrcW,
//   ALUResultW, ReadDataW, PCPlus4W,
//   RdW                               : M->W pipeline register contents
//   ResultW                           : selected writeback value
//   Rs1D, Rs2D / RD1D, RD2D           : decode register reads with write bypass
//   RegWriteM, RdM, ALUResultM        : M-stage producer for forwarding
//   Rs1E, Rs2E, RD1E, RD2E            : E-stage operand indices and register values
//   SrcAE, WriteDataE                 : forwarded E operands
//   InstRetW                          : retired-instruction counter
//   DbgA0                             : stored x10
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = 32,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidW,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [DATA_WIDTH-1:0] ALUResultW,
    input  logic [DATA_WIDTH-1:0] ReadDataW,
    input  logic [DATA_WIDTH-1:0] PCPlus4W,
    input  logic [REG_IDX_W-1:0]  RdW,
    output logic [DATA_WIDTH-1:0] ResultW,
    input  logic [REG_IDX_W-1:0]  Rs1D,
    input  logic [REG_IDX_W-1:0]  Rs2D,
    output logic [DATA_WIDTH-1:0] RD1D,
    output logic [DATA_WIDTH-1:0] RD2D,
    input  logic                  RegWriteM,
    input  logic [REG_IDX_W-1:0]  RdM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [REG_IDX_W-1:0]  Rs1E,
    input  logic [REG_IDX_W-1:0]  Rs2E,
    input  logic [DATA_WIDTH-1:0] RD1E,
    input  logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] SrcAE,
    output logic [DATA_WIDTH-1:0] WriteDataE,
    output logic [CNT_WIDTH-1:0]  InstRetW,
    output logic [DATA_WIDTH-1:0] DbgA0
);

    logic           commit;
    logic           w_fwd_en;
    fwd_sel_e       sel_a;
    fwd_sel_e       sel_b;
    logic [CNT_WIDTH-1:0] inst_ret;

    // The reserved encoding 11 falls back to the ALU result.
    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = ALUResultW;
        endcase
    end

    assign commit   = ValidW && RegWriteW && (RdW != '0);
    assign w_fwd_en = ValidW && RegWriteW;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (commit),
        .waddr  (RdW),
        .wdata  (ResultW),
        .raddr1 (Rs1D),
        .raddr2 (Rs2D),
        .rdata1 (RD1D),
        .rdata2 (RD2D),
        .dbg_a0 (DbgA0)
    );

    assign sel_a = fwd_select(Rs1E, RegWriteM, RdM, w_fwd_en, RdW);
    assign sel_b = fwd_select(Rs2E, RegWriteM, RdM, w_fwd_en, RdW);

    always_comb begin
        SrcAE = RD1E;
        case (sel_a)
            FWD_M:   SrcAE = ALUResultM;
            FWD_W:   SrcAE = ResultW;
            default: SrcAE = RD1E;
        endcase
    end

    always_comb begin
        WriteDataE = RD2E;
        case (sel_b)
            FWD_M:   WriteDataE = ALUResultM;
            FWD_W:   WriteDataE = ResultW;
            default: WriteDataE = RD2E;
        endcase
    end

    // Every valid W instruction retires, whether or not it writes a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ret <= '0;
        end else if (ValidW) begin
            inst_ret <= inst_ret + CNT_WIDTH'(1);
        end
    end

    assign InstRetW = inst_ret;

endmodule
